// File: rtl/mem_access_unit_pkg.sv
// Shared types for the MEM-stage access unit: size encodings, FSM states,
// and the alignment helpers used by the top level.
package mem_pkg;

  localparam int MEM_AW_DEF = 5;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    RMW_RD,
    RMW_WR,
    DONE
  } state_e;

  // Reserved size behaves as a full word everywhere.
  function automatic logic is_word(input size_e sz);
    return (sz == SZ_WORD) || (sz == SZ_RSVD);
  endfunction

  function automatic logic [1:0] align_off(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return off;
      SZ_HALF: return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
    return align_off(sz, off) != off;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Little-endian lane handling: extracts/extends load data from a memory word
// and merges sub-word store data into a previously read word.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  off_i,
  input  size_e       size_i,
  input  logic        signed_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ldata_o,
  output logic [31:0] mdata_o
);

  logic [7:0]  byte_l;
  logic [15:0] half_l;

  assign byte_l = rdata_i[{off_i, 3'b000} +: 8];
  assign half_l = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    ldata_o = rdata_i;
    mdata_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        ldata_o = {{24{signed_i & byte_l[7]}}, byte_l};
        mdata_o = rdata_i;
        mdata_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        ldata_o = {{16{signed_i & half_l[15]}}, half_l};
        mdata_o = rdata_i;
        if (off_i[1]) mdata_o[31:16] = wdata_i[15:0];
        else          mdata_o[15:0]  = wdata_i[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: one load/store per handshake, word-wide memory cycles,
// read-modify-write for sub-word stores. Optional: MEM_ACCESS_MISALIGN_EXC_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = MEM_AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Req_Valid,
  output logic              Req_Ready,
  input  logic              Req_Load,
  input  logic [1:0]        Req_Size,
  input  logic              Req_Signed,
  input  logic [ADDR_W-1:0] Req_Addr,
  input  logic [31:0]       Req_WData,
  output logic              Resp_Valid,
  output logic [31:0]       Load_Data,
  output logic              Stall,
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
  output logic              Misalign_Exc,
`endif
  output logic [MEM_AW-1:0] Mem_Address,
  output logic [31:0]       Mem_Write_Data,
  output logic              Mem_Read,
  output logic              Mem_Write,
  input  logic [31:0]       Mem_Read_Data,
  input  logic              Mem_Ready
);

  state_e            state_q;
  logic [1:0]        off_q;
  size_e             size_q;
  logic              signed_q;
  logic [31:0]       wdata_q;
  logic              req_ready_q, resp_valid_q, stall_q, mem_read_q, mem_write_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q, load_data_q;
  size_e             req_size;
  logic [1:0]        req_off;
  logic [31:0]       ext_data, merge_data;
  logic              unused_addr;
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
  logic              exc_q;
  assign Misalign_Exc = exc_q;
`endif

  assign req_size    = size_e'(Req_Size);
  assign req_off     = align_off(req_size, Req_Addr[1:0]);
  assign unused_addr = ^Req_Addr[ADDR_W-1:MEM_AW+2];

  assign Req_Ready      = req_ready_q;
  assign Resp_Valid     = resp_valid_q;
  assign Load_Data      = load_data_q;
  assign Stall          = stall_q;
  assign Mem_Address    = mem_addr_q;
  assign Mem_Write_Data = mem_wdata_q;
  assign Mem_Read       = mem_read_q;
  assign Mem_Write      = mem_write_q;

  mem_lane_align u_lane (
    .off_i    (off_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .rdata_i  (Mem_Read_Data),
    .wdata_i  (wdata_q),
    .ldata_o  (ext_data),
    .mdata_o  (merge_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      off_q        <= '0;
      size_q       <= SZ_BYTE;
      signed_q     <= 1'b0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      stall_q      <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      load_data_q  <= '0;
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
      exc_q        <= 1'b0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
      exc_q        <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (Req_Valid && req_ready_q) begin
            off_q       <= req_off;
            size_q      <= req_size;
            signed_q    <= Req_Signed;
            wdata_q     <= Req_WData;
            mem_addr_q  <= Req_Addr[MEM_AW+1:2];
            req_ready_q <= 1'b0;
            stall_q     <= 1'b1;
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
            if (is_misaligned(req_size, Req_Addr[1:0])) begin
              resp_valid_q <= 1'b1;
              exc_q        <= 1'b1;
              state_q      <= DONE;
            end else
`endif
            if (Req_Load) begin
              mem_read_q <= 1'b1;
              state_q    <= RD;
            end else if (is_word(req_size)) begin
              mem_write_q <= 1'b1;
              mem_wdata_q <= Req_WData;
              state_q     <= WR;
            end else begin
              mem_read_q <= 1'b1;
              state_q    <= RMW_RD;
            end
          end
        end
        RD: if (Mem_Ready) begin
          mem_read_q   <= 1'b0;
          load_data_q  <= ext_data;
          resp_valid_q <= 1'b1;
          state_q      <= DONE;
        end
        WR, RMW_WR: if (Mem_Ready) begin
          mem_write_q  <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= DONE;
        end
        // Read strobe hands over directly to the write strobe with the merged word.
        RMW_RD: if (Mem_Ready) begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b1;
          mem_wdata_q <= merge_data;
          state_q     <= RMW_WR;
        end
        DONE: begin
          stall_q     <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a 32-word behavioural memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Req_Valid = 1'b0, Req_Load = 1'b0, Req_Signed = 1'b0;
  logic [1:0]  Req_Size = 2'b00;
  logic [31:0] Req_Addr = '0, Req_WData = '0;
  logic        Req_Ready, Resp_Valid, Stall, Mem_Read, Mem_Write;
  logic [31:0] Load_Data, Mem_Write_Data, Mem_Read_Data;
  logic [4:0]  Mem_Address;
  logic        Mem_Ready = 1'b1;
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
  logic        Misalign_Exc;
`endif

  mem_access_unit #(.ADDR_W(32), .MEM_AW(5)) dut (
    .clk            (clk),
    .reset          (reset),
    .Req_Valid      (Req_Valid),
    .Req_Ready      (Req_Ready),
    .Req_Load       (Req_Load),
    .Req_Size       (Req_Size),
    .Req_Signed     (Req_Signed),
    .Req_Addr       (Req_Addr),
    .Req_WData      (Req_WData),
    .Resp_Valid     (Resp_Valid),
    .Load_Data      (Load_Data),
    .Stall          (Stall),
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
    .Misalign_Exc   (Misalign_Exc),
`endif
    .Mem_Address    (Mem_Address),
    .Mem_Write_Data (Mem_Write_Data),
    .Mem_Read       (Mem_Read),
    .Mem_Write      (Mem_Write),
    .Mem_Read_Data  (Mem_Read_Data),
    .Mem_Ready      (Mem_Ready)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  assign Mem_Read_Data = mem[Mem_Address];
  always @(posedge clk) if (Mem_Write && Mem_Ready) mem[Mem_Address] <= Mem_Write_Data;

  typedef struct {
    bit          is_load;
    bit          exc;
    logic [31:0] data;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0, n_err = 0, cyc = 0, extra_wait = 0;
  logic [31:0] last_load = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] ref_off(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b00) return a[1:0];
    if (sz == 2'b01) return {a[1], 1'b0};
    return 2'b00;
  endfunction

  function automatic logic [31:0] ref_mask(input logic [1:0] sz);
    if (sz == 2'b00) return 32'h0000_00FF;
    if (sz == 2'b01) return 32'h0000_FFFF;
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [1:0] sz,
                                            input logic [1:0] off, input logic [31:0] wd);
    logic [31:0] m;
    m = ref_mask(sz) << (8 * off);
    return (old & ~m) | ((wd << (8 * off)) & m);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input bit sg, input logic [1:0] off);
    logic [31:0] v;
    bit msb;
    v   = (w >> (8 * off)) & ref_mask(sz);
    msb = (sz == 2'b00) ? v[7] : v[15];
    if (sg && sz[1] == 1'b0 && msb) v = v | ~ref_mask(sz);
    return v;
  endfunction

  function automatic bit misal(input logic [1:0] sz, input logic [31:0] a);
    return ref_off(sz, a) != a[1:0];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    chk("strobe_excl", {31'b0, Mem_Read & Mem_Write}, 32'd0);
    if (Resp_Valid) begin
      if (sb.size() == 0) begin
        chk("spurious_resp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk(e.is_load ? "load_data" : "ld_kept", Load_Data, e.data);
        chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
        chk("misalign_exc", {31'b0, Misalign_Exc}, {31'b0, e.exc});
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns at #1 after the accepting edge (cycle T+1 in latency terms).
  task automatic issue(input bit ld, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd, input bit track);
    exp_t e;
    logic [4:0] wi;
    int n;
    Req_Load = ld; Req_Size = sz; Req_Signed = sg; Req_Addr = a; Req_WData = wd;
    Req_Valid = 1'b1;
    n = 0;
    while (!Req_Ready && n < 100) begin tick(); n++; end
    if (!Req_Ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      Req_Valid = 1'b0;
      return;
    end
    tick();
    Req_Valid = 1'b0;
    if (!track) return;
    e.acc = cyc; e.is_load = ld; e.exc = 1'b0;
    wi = a[6:2];
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
    if (misal(sz, a)) begin
      e.exc = 1'b1; e.data = last_load; e.lat = 1;
      sb.push_back(e);
      return;
    end
`endif
    if (ld) begin
      last_load = ref_load(ref_mem[wi], sz, sg, ref_off(sz, a));
      e.lat = 2 + extra_wait;
    end else begin
      ref_mem[wi] = ref_store(ref_mem[wi], sz, ref_off(sz, a), wd);
      e.lat = (sz[1] ? 2 : 3) + extra_wait;
    end
    e.data = last_load;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin tick(); n++; end
    if (sb.size() != 0) begin
      chk("resp_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    #2 reset = 1'b1;
    #1;
    chk("rst_req_ready", {31'b0, Req_Ready}, 32'd1);
    chk("rst_outputs", {27'b0, Resp_Valid, Stall, Mem_Read, Mem_Write, 1'b0}, 32'd0);
    chk("rst_load_data", Load_Data, 32'd0);
    chk("rst_mem_addr", {27'b0, Mem_Address}, 32'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    tick();

    // word store then load at 0x24
    issue(1'b0, 2'b10, 1'b0, 32'h24, 32'h0000_7A10, 1'b1);
    chk("st_addr", {27'b0, Mem_Address}, 32'd9);
    chk("st_wstrobe", {30'b0, Mem_Write, Mem_Read}, 32'b10);
    chk("st_wdata", Mem_Write_Data, 32'h0000_7A10);
    chk("st_stall", {30'b0, Stall, Req_Ready}, 32'b10);
    drain();
    issue(1'b1, 2'b10, 1'b0, 32'h24, 32'h0, 1'b1);
    drain();
    chk("ld_word_const", Load_Data, 32'h0000_7A10);

    // signed / unsigned byte loads
    issue(1'b0, 2'b10, 1'b0, 32'h24, 32'h00F0_8000, 1'b1); drain();
    issue(1'b1, 2'b00, 1'b1, 32'h25, 32'h0, 1'b1);         drain();
    chk("ld_sbyte_const", Load_Data, 32'hFFFF_FF80);
    issue(1'b1, 2'b00, 1'b0, 32'h25, 32'h0, 1'b1);         drain();
    chk("ld_ubyte_const", Load_Data, 32'h0000_0080);

    // half store read-modify-write into word 8
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0000_7A20, 1'b1); drain();
    issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h1234_BEEF, 1'b1);
    chk("rmw_rd_strobe", {30'b0, Mem_Write, Mem_Read}, 32'b01);
    chk("rmw_addr", {27'b0, Mem_Address}, 32'd8);
    tick();
    chk("rmw_wr_strobe", {30'b0, Mem_Write, Mem_Read}, 32'b10);
    chk("rmw_wdata", Mem_Write_Data, 32'hBEEF_7A20);
    drain();
    chk("rmw_mem", mem[8], 32'hBEEF_7A20);
    issue(1'b1, 2'b01, 1'b1, 32'h22, 32'h0, 1'b1); drain();
    issue(1'b1, 2'b01, 1'b0, 32'h20, 32'h0, 1'b1); drain();

    // byte stores into every lane of word 16, then mixed reads
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 2'b00, 1'b0, 32'h40 + 32'(i), {24'hABCDEF, 8'(8'h70 + i * 8'h11)}, 1'b1);
      drain();
    end
    chk("byte_merge_mem", mem[16], 32'hA392_8170);
    issue(1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1); drain();
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 2'b00, 1'b1, 32'h40 + 32'(i), 32'h0, 1'b1); drain();
    end
    issue(1'b1, 2'b01, 1'b0, 32'h42, 32'h0, 1'b1); drain();
    issue(1'b1, 2'b01, 1'b1, 32'h42, 32'h0, 1'b1); drain();

    // reserved size acts as word
    issue(1'b0, 2'b11, 1'b0, 32'h44, 32'hCAFE_F00D, 1'b1); drain();
    issue(1'b1, 2'b11, 1'b1, 32'h44, 32'h0, 1'b1);         drain();

    // wait states during RD
    Mem_Ready = 1'b0;
    extra_wait = 3;
    issue(1'b1, 2'b10, 1'b0, 32'h24, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("ws_read", {31'b0, Mem_Read}, 32'd1);
      chk("ws_addr", {27'b0, Mem_Address}, 32'd9);
      chk("ws_stall_rdy", {30'b0, Stall, Req_Ready}, 32'b10);
      tick();
    end
    Mem_Ready = 1'b1;
    drain();
    extra_wait = 0;

    // misaligned word load
    issue(1'b1, 2'b10, 1'b0, 32'h26, 32'h0, 1'b1);
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
    chk("misal_no_strobe", {30'b0, Mem_Write, Mem_Read}, 32'd0);
    chk("misal_exc_t1", {31'b0, Misalign_Exc}, 32'd1);
`else
    chk("misal_addr", {27'b0, Mem_Address}, 32'd9);
    chk("misal_read", {31'b0, Mem_Read}, 32'd1);
`endif
    drain();

    // reset while in RMW_WR
    issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h0000_1234, 1'b0);
    tick();
    chk("pre_rst_write", {31'b0, Mem_Write}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_drop_write", {30'b0, Mem_Write, Mem_Read}, 32'd0);
    #3 reset = 1'b0;
    last_load = '0;
    tick();
    chk("post_rst_ready", {31'b0, Req_Ready}, 32'd1);
    chk("post_rst_ld", Load_Data, 32'd0);
    repeat (3) tick();
    chk("rst_mem_intact", mem[8], ref_mem[8]);

    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1); drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage initiator that drives the word-addressed data memory. Sits between the EX/MEM pipeline register and the memory responder.
- Accepts one load or store per handshake and translates byte, halfword and word accesses into word-wide memory cycles. Sub-word stores use read-modify-write.
- Returns sign- or zero-extended load data and holds the pipeline stalled while an access is in flight.

Parameters:
- ADDR_W, 32, byte-address width from the pipeline
- MEM_AW, 5, word-index width on the memory side (32 words)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- Req_Valid  in  1  request present from EX/MEM
- Req_Ready  out  1  unit can accept a request this cycle
- Req_Load  in  1  1=load, 0=store
- Req_Size  in  2  00=byte, 01=half, 10=word, 11=reserved (treated as word)
- Req_Signed  in  1  sign-extend load result
- Req_Addr  in  ADDR_W  byte address
- Req_WData  in  32  store data, right-aligned
- Resp_Valid  out  1  one-cycle pulse: access complete
- Load_Data  out  32  extended load result, valid with Resp_Valid
- Stall  out  1  high from acceptance until the Resp_Valid cycle, inclusive
- Mem_Address  out  MEM_AW  word index = Req_Addr[MEM_AW+1:2]
- Mem_Write_Data  out  32  word to write
- Mem_Read  out  1  read strobe
- Mem_Write  out  1  write strobe
- Mem_Read_Data  in  32  word returned
- Mem_Ready  in  1  memory completes the current strobe at this posedge

Behaviour:
- Reset values: all outputs 0, except Req_Ready=1. FSM goes to IDLE. Latched request cleared.
- Reset asserted mid-access: strobes drop immediately and asynchronously. No Resp_Valid is produced.
- Handshake: a request is accepted on a posedge with Req_Valid && Req_Ready.
  - On acceptance, addr, wdata, size, signed and load are latched.
  - Req_Ready is high only in IDLE.
- FSM states: IDLE, RD, WR, RMW_RD, RMW_WR, DONE.
  - IDLE, load accepted -> RD.
  - IDLE, word store accepted -> WR.
  - IDLE, byte or half store accepted -> RMW_RD.
  - RD: Mem_Read=1. When Mem_Ready: capture Mem_Read_Data -> DONE.
  - WR: Mem_Write=1, Mem_Write_Data=latched wdata. When Mem_Ready -> DONE.
  - RMW_RD: Mem_Read=1. When Mem_Ready: merge new bytes into the read word -> RMW_WR.
  - RMW_WR: Mem_Write=1 with the merged word. When Mem_Ready -> DONE.
  - DONE: Resp_Valid=1 for one cycle -> IDLE.
- Strobe rules:
  - Mem_Read and Mem_Write are never high in the same cycle.
  - Strobes are registered.
  - Mem_Address and Mem_Write_Data stay stable while a strobe is high.
  - If Mem_Ready is low, the strobe is held with no timeout.
- Minimum latency, with Mem_Ready tied high:
  - Load or word store: accept at T, strobe at T+1, Resp_Valid at T+2.
  - Sub-word store: Resp_Valid at T+3.
- Lane select (little-endian):
  - Byte lane = addr[1:0]. Half lane = addr[1] (0 selects bits 15:0).
  - Load result is the selected lane shifted down. Bits above it are filled with the lane's MSB if Req_Signed, else 0.
- Store merge:
  - Byte: wdata[7:0] replaces lane addr[1:0].
  - Half: wdata[15:0] replaces lane addr[1].
  - Word: full word written.
- Misalignment (half with addr[0]=1, or word with addr[1:0]!=0), without the optional feature: the offending low bits are forced to 0 and the access proceeds.
- Load_Data holds its value until the next load completes. After a store, Load_Data is unchanged.
- Req_Valid while busy is ignored; the requester must hold it until Req_Ready.

Optional Feature:
- Macro: MEM_ACCESS_MISALIGN_EXC_EN.
- Defined:
  - Adds output port Misalign_Exc (1 bit, reset 0).
  - A misaligned request is accepted, and the FSM goes directly to DONE with no memory strobe.
  - Resp_Valid and Misalign_Exc pulse together at T+1. Load_Data is unchanged.
- Undefined: no Misalign_Exc port; alignment forcing as described under Behaviour.

Decomposition:
- Shared package mem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - FSM state typedef and encodings
  - MEM_AW default
- One natural sub-module: mem_lane_align. It is combinational and does load extraction/extension and store merge from (addr[1:0], size, signed).

Test Plan:
- Word store then load, Mem_Ready=1: store 0x00007A10 to addr 0x24, then load addr 0x24.
  - Mem_Address=9, Mem_Write=1 at T+1.
  - Load returns Load_Data=0x00007A10 with Resp_Valid at T+2.
- Signed byte load: memory word 9 = 0x00F08000, load byte at addr 0x25 with Req_Signed=1 -> Load_Data=0xFFFFFF80.
  - Same access with Req_Signed=0 -> 0x00000080.
- Half store RMW: word 8 = 0x00007A20, store half 0xBEEF at addr 0x22.
  - Read strobe, then write strobe with 0xBEEF7A20.
  - Resp_Valid at T+3.
- Memory wait states: Mem_Ready held low 3 cycles during RD.
  - Mem_Read and Mem_Address stay stable.
  - Stall stays high; Req_Ready stays 0.
  - Resp_Valid one cycle after Mem_Ready.
- Reset mid-access: assert reset while in RMW_WR.
  - Mem_Write drops in the same cycle.
  - No Resp_Valid is produced.
  - Req_Ready=1 after release.
- Misaligned word load at addr 0x26:
  - Macro undefined: access word 9, addr bits forced to 0.
  - Macro defined: Misalign_Exc=1 at T+1 and no strobe.
